// File: rtl/posit_pkg.sv
// Shared posit<N,ES> constants and the unpacked-value record exchanged between
// the posit decode side and this encoder.
package posit_pkg;

  localparam int N     = 8;
  localparam int ES    = 2;
  localparam int LOG_N = 3;
  localparam int FW    = 5;
  localparam int SW    = LOG_N + ES + 2;

  localparam int MAXSCALE = (N - 2) * (2 ** ES);

  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
    logic                 sticky;
  } posit_unpacked_t;

endpackage

// File: rtl/posit_regime_pack.sv
// Stage-1 combinational packer: builds {regime, exponent, fraction}, truncates to
// N-1 magnitude bits and extracts guard/sticky, clamping out-of-range scales.
module posit_regime_pack
  import posit_pkg::*;
(
  input  logic signed [SW-1:0] i_scale,
  input  logic [FW-1:0]        i_frac,
  input  logic                 i_sticky,
  output logic [N-2:0]         o_mag,
  output logic                 o_g,
  output logic                 o_s,
  output logic                 o_sat
);

  localparam int XW = 2 * N + ES + FW;
  localparam int KW = SW - ES;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAXSCALE);
  localparam logic signed [SW-1:0] MIN_S = SW'(-MAXSCALE);

  logic signed [KW-1:0] w_k;
  logic [ES-1:0]        w_e;
  logic [XW-1:0]        w_base;
  logic [XW-1:0]        w_shifted;
  logic [LOG_N-1:0]     w_shamt;

  // Upper scale bits are floor(scale / 2^ES); the low bits are the exponent field.
  assign w_k = i_scale[SW-1:ES];
  assign w_e = i_scale[ES-1:0];

  // A run of N identical regime bits sits above the terminator; shifting left
  // leaves exactly the required run length at the top of the vector.
  assign w_base = (w_k < 0) ? {{N{1'b0}}, 1'b1, w_e, i_frac, {(N-1){1'b0}}}
                            : {{N{1'b1}}, 1'b0, w_e, i_frac, {(N-1){1'b0}}};

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_shamt = '0;
    if (w_k < 0) w_shamt = LOG_N'(N + int'(w_k));
    else         w_shamt = LOG_N'(N - 1 - int'(w_k));
  end

  assign w_shifted = w_base << w_shamt;

  always_comb begin
    o_mag = w_shifted[XW-1 -: N-1];
    o_g   = w_shifted[XW-N];
    o_s   = (|w_shifted[XW-N-1:0]) | i_sticky;
    o_sat = 1'b0;
    if (i_scale > MAX_S) begin
      o_mag = MAXPOS[N-2:0];
      o_g   = 1'b0;
      o_s   = 1'b0;
      o_sat = 1'b1;
    end else if (i_scale < MIN_S) begin
      o_mag = MINPOS[N-2:0];
      o_g   = 1'b0;
      o_s   = 1'b0;
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Two-stage pipelined posit encoder: regime/shift in stage 1, round-to-nearest-even
// and sign/special packing in stage 2, valid/ready flow control at both ends.
module posit_encode_pipe
  import posit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic          out_sat
);

  typedef struct packed {
    logic         sign;
    logic         zero;
    logic         nar;
    logic [N-2:0] mag;
    logic         g;
    logic         s;
    logic         sat;
  } s1_t;

  posit_unpacked_t w_in;
  s1_t             w_s1_next;
  s1_t             r_s1;
  logic            r_s1_v;
  logic            r_s2_v;
  logic            w_s1_ready;
  logic            w_s2_ready;
  logic            w_round;
  logic [N-1:0]    w_mag_r;
  logic [N-1:0]    w_posit;
  logic            w_sat;
  logic [N-1:0]    r_out_posit;
  logic            r_out_sat;

  assign w_in = '{sign: in_sign, zero: in_zero, nar: in_nar, scale: in_scale,
                  frac: in_frac, sticky: in_sticky};

  assign w_s2_ready = ~r_s2_v | out_ready;
  assign w_s1_ready = ~r_s1_v | w_s2_ready;
  assign in_ready   = w_s1_ready;

  posit_regime_pack u_regime_pack (
    .i_scale  (w_in.scale),
    .i_frac   (w_in.frac),
    .i_sticky (w_in.sticky),
    .o_mag    (w_s1_next.mag),
    .o_g      (w_s1_next.g),
    .o_s      (w_s1_next.s),
    .o_sat    (w_s1_next.sat)
  );

  assign w_s1_next.sign = w_in.sign;
  assign w_s1_next.zero = w_in.zero;
  assign w_s1_next.nar  = w_in.nar;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_s1_v <= 1'b0;
    else if (w_s1_ready) r_s1_v <= in_valid;
  end

  // NOTE: the stage-1 payload has no reset; it is only observed while r_s1_v
  // is set, and r_s1_v itself is reset.
  always_ff @(posedge clk) begin
    if (w_s1_ready && in_valid) r_s1 <= w_s1_next;
  end

  always_comb begin
    w_round = r_s1.g & (r_s1.mag[0] | r_s1.s);
    w_mag_r = {1'b0, r_s1.mag} + N'(w_round);
    w_sat   = r_s1.sat;
    if (w_mag_r == NAR) begin
      w_mag_r = MAXPOS;
      w_sat   = 1'b1;
    end else if (w_mag_r == '0) begin
      w_mag_r = MINPOS;
      w_sat   = 1'b1;
    end
    w_posit = r_s1.sign ? -w_mag_r : w_mag_r;
    if (r_s1.nar) begin
      w_posit = NAR;
      w_sat   = 1'b0;
    end else if (r_s1.zero) begin
      w_posit = '0;
      w_sat   = 1'b0;
    end
  end

  // The output payload is reset as well so the port reads zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v      <= 1'b0;
      r_out_posit <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out_posit <= w_posit;
        r_out_sat   <= w_sat;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_posit = r_out_posit;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Self-checking bench for posit_encode_pipe: a value-level model (nearest posit by
// real arithmetic) feeds a scoreboard checked against every output transfer.
module tb_posit_encode_pipe;
  import posit_pkg::*;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic          in_sign   = 1'b0;
  logic          in_zero   = 1'b0;
  logic          in_nar    = 1'b0;
  logic [SW-1:0] in_scale  = '0;
  logic [FW-1:0] in_frac   = '0;
  logic          in_sticky = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_posit;
  logic          out_sat;

  posit_encode_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sign; logic zero; logic nar;
    int scale; int frac; logic sticky;
    logic [N-1:0] ep; logic es; bit has_exp;
  } vec_t;

  typedef struct {
    logic [N-1:0] posit; logic sat; int cyc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  vec_t dir[$];
  bit   rand_ready   = 1'b0;
  bit   tput_mode    = 1'b0;
  int   last_out_cyc = -1;
  int   n_out        = 0;
  bit   prev_stall   = 1'b0;
  logic [N-1:0] prev_posit;
  logic prev_sat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  // Real value of a positive posit whose w magnitude bits (below the sign) are m.
  function automatic real pval(input int m, input int w);
    int  i   = w - 1;
    int  run = 0;
    int  k;
    int  e   = 0;
    real f   = 1.0;
    real wt  = 0.5;
    bit  r;
    r = m[w-1];
    while (i >= 0 && m[i] == r) begin run++; i--; end
    k = r ? run - 1 : -run;
    i--;
    for (int j = 0; j < ES; j++) begin
      e = e * 2;
      if (i >= 0) begin e += int'(m[i]); i--; end
    end
    while (i >= 0) begin
      if (m[i]) f += wt;
      wt = wt / 2.0;
      i--;
    end
    return pow2(k * (1 << ES) + e) * f;
  endfunction

  // Nearest posit by value; ties are decided against the posit one bit longer.
  function automatic exp_t model(input vec_t v);
    exp_t r;
    real  x, mid;
    int   p;
    r.cyc = 0;
    r.sat = 1'b0;
    if (v.nar)  begin r.posit = NAR; return r; end
    if (v.zero) begin r.posit = '0;  return r; end
    x = pow2(v.scale) * (1.0 + real'(v.frac) / 32.0 + (v.sticky ? pow2(-20) : 0.0));
    r.sat = (v.scale > MAXSCALE) || (v.scale < -MAXSCALE);
    if (x >= pval(127, 7))    p = 127;
    else if (x < pval(1, 7))  p = 1;
    else begin
      p = 1;
      while (p < 127 && pval(p + 1, 7) <= x) p++;
      mid = pval(2 * p + 1, 8);
      if (x > mid || (x == mid && (p % 2) == 1)) p++;
      if (p > 127) begin p = 127; r.sat = 1'b1; end
    end
    r.posit = N'(v.sign ? -p : p);
    return r;
  endfunction

  function automatic vec_t mk(input logic sign, input logic zero, input logic nar,
                              input int scale, input int frac, input logic sticky,
                              input logic [N-1:0] ep, input logic es);
    vec_t v;
    v.sign = sign; v.zero = zero; v.nar = nar;
    v.scale = scale; v.frac = frac; v.sticky = sticky;
    v.ep = ep; v.es = es; v.has_exp = 1'b1;
    return v;
  endfunction

  task automatic send(input vec_t v);
    exp_t m;
    bit   ok = 1'b0;
    in_valid  = 1'b1;
    in_sign   = v.sign;
    in_zero   = v.zero;
    in_nar    = v.nar;
    in_scale  = SW'(v.scale);
    in_frac   = FW'(v.frac);
    in_sticky = v.sticky;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    m = model(v);
    m.cyc = cyc;
    if (v.has_exp) begin
      check($sformatf("model_posit_s%0d", v.scale), 32'(m.posit), 32'(v.ep));
      check($sformatf("model_sat_s%0d", v.scale), 32'(m.sat), 32'(v.es));
    end
    if (ok) sb.push_back(m);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.sign = 1'($urandom_range(0, 1));
    v.zero = 1'b0; v.nar = 1'b0;
    v.scale = int'($urandom_range(0, 56)) - 28;
    v.frac = int'($urandom_range(0, 31));
    v.sticky = 1'($urandom_range(0, 1));
    v.ep = '0; v.es = 1'b0; v.has_exp = 1'b0;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Compare process: every output transfer against the scoreboard, plus hold-while-stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_posit", 32'(out_posit), 32'(prev_posit));
        check("hold_sat", 32'(out_sat), 32'(prev_sat));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_posit", 32'(out_posit), 32'(e.posit));
          check("out_sat", 32'(out_sat), 32'(e.sat));
          if (tput_mode) begin
            check("latency", 32'(cyc - e.cyc), 32'd2);
            if (last_out_cyc >= 0) check("throughput_gap", 32'(cyc - last_out_cyc), 32'd1);
            last_out_cyc = cyc;
          end
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_posit = out_posit;
      prev_sat   = out_sat;
    end
  end

  initial begin
    int base;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_posit", 32'(out_posit), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    dir.push_back(mk(0, 0, 0,   0,  0, 0, 8'h40, 0));
    dir.push_back(mk(0, 0, 0,   1,  0, 0, 8'h48, 0));
    dir.push_back(mk(0, 0, 0,  -1,  0, 0, 8'h38, 0));
    dir.push_back(mk(1, 0, 0,   0,  0, 0, 8'hC0, 0));
    dir.push_back(mk(0, 0, 0,   0,  2, 0, 8'h40, 0));
    dir.push_back(mk(0, 0, 0,   0,  6, 0, 8'h42, 0));
    dir.push_back(mk(0, 0, 0,   0,  2, 1, 8'h41, 0));
    dir.push_back(mk(0, 0, 0,  24,  0, 0, 8'h7F, 0));
    dir.push_back(mk(0, 0, 0,  30,  0, 0, 8'h7F, 1));
    dir.push_back(mk(0, 0, 0, -24,  0, 0, 8'h01, 0));
    dir.push_back(mk(0, 0, 0, -30,  0, 0, 8'h01, 1));
    dir.push_back(mk(1, 0, 0,  30,  0, 0, 8'h81, 1));
    dir.push_back(mk(0, 0, 1,   5,  3, 0, 8'h80, 0));
    dir.push_back(mk(0, 1, 0,   5,  3, 0, 8'h00, 0));
    dir.push_back(mk(0, 1, 1,   5,  3, 0, 8'h80, 0));
    dir.push_back(mk(0, 0, 0,   5, 16, 0, 8'h66, 0));
    dir.push_back(mk(0, 0, 0, -21,  0, 0, 8'h02, 0));
    dir.push_back(mk(1, 0, 0,  -1,  0, 0, 8'hC8, 0));
    foreach (dir[i]) send(dir[i]);
    drain();

    rand_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 10; i++) send(rand_vec());
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check("stall_stream_count", 32'(n_out - base), 32'd10);

    tput_mode    = 1'b1;
    last_out_cyc = -1;
    base = n_out;
    for (int i = 0; i < 10; i++) send(rand_vec());
    drain();
    tput_mode = 1'b0;
    check("tput_stream_count", 32'(n_out - base), 32'd10);

    out_ready = 1'b0;
    send(mk(0, 0, 0, 1, 0, 0, 8'h48, 0));
    send(mk(0, 0, 0, 2, 0, 0, 8'h50, 0));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_posit", 32'(out_posit), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("postrst_no_stale", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
